// File: rtl/simon_color_scheduler.sv
// Color display scheduler: plays back the stored pattern or echoes button presses,
// giving the shared color display exactly one owner at a time.
module simon_color_scheduler #(
    parameter int unsigned SEQ_DEPTH  = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ON_TICKS   = 3,
    parameter int unsigned OFF_TICKS  = 1,
    parameter int unsigned ECHO_TICKS = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              Start_play,
    input  logic [5:0]        Level,
    output logic [ADDR_W-1:0] Seq_addr,
    input  logic [1:0]        Seq_color,
    input  logic              Btn_U,
    input  logic              Btn_R,
    input  logic              Btn_D,
    input  logic              Btn_L,
    output logic [3:0]        color_on,
    output logic              busy,
    output logic              play_done,
    output logic              echo_valid,
    output logic [1:0]        echo_color,
    output logic              q_Idle,
    output logic              q_Play_On,
    output logic              q_Play_Off,
    output logic              q_Echo
);

    localparam int unsigned MAX_T01 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAX_T   = (MAX_T01 > ECHO_TICKS) ? MAX_T01 : ECHO_TICKS;
    localparam int unsigned TCNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int unsigned LEN_W   = $clog2(SEQ_DEPTH + 1);
    localparam int unsigned CMP_W   = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    // One-hot state bit positions
    localparam int unsigned I_IDLE = 0;
    localparam int unsigned I_ON   = 1;
    localparam int unsigned I_OFF  = 2;
    localparam int unsigned I_ECHO = 3;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_ON   = 4'b0010;
    localparam logic [3:0] ST_OFF  = 4'b0100;
    localparam logic [3:0] ST_ECHO = 4'b1000;

    logic [3:0]        state;
    logic [3:0]        state_next;
    logic [TCNT_W-1:0] tcnt;
    logic [LEN_W-1:0]  len_q;
    logic              pending;

    logic [LEN_W-1:0]  eff_len_c;
    logic              len_nz_c;
    logic              btn_any_c;
    logic [1:0]        btn_code_c;
    logic [TCNT_W-1:0] dur_c;
    logic              expire_c;
    logic              last_c;
    logic              go_play_c;

    assign eff_len_c = (32'(Level) > SEQ_DEPTH) ? LEN_W'(SEQ_DEPTH) : LEN_W'(Level);
    assign len_nz_c  = (eff_len_c != '0);
    assign btn_any_c = Btn_U | Btn_R | Btn_D | Btn_L;
    assign go_play_c = pending | (Start_play & len_nz_c);
    assign last_c    = ((CMP_W'(Seq_addr) + CMP_W'(1)) == CMP_W'(len_q));

    // Press priority U > R > D > L
    always_comb begin
        btn_code_c = 2'd3;
        if (Btn_U)      btn_code_c = 2'd0;
        else if (Btn_R) btn_code_c = 2'd1;
        else if (Btn_D) btn_code_c = 2'd2;
    end

    // Duration of the current state, expressed as the terminal tcnt value
    always_comb begin
        dur_c = '0;
        if (state[I_ON])   dur_c = TCNT_W'(ON_TICKS - 1);
        if (state[I_OFF])  dur_c = TCNT_W'(OFF_TICKS - 1);
        if (state[I_ECHO]) dur_c = TCNT_W'(ECHO_TICKS - 1);
    end

    assign expire_c = Tick && (tcnt == dur_c);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (1'b1)
            state[I_IDLE]: begin
                if (Start_play) begin
                    if (len_nz_c) state_next = ST_ON;
                end else if (btn_any_c) begin
                    state_next = ST_ECHO;
                end
            end
            state[I_ON]:   if (expire_c) state_next = ST_OFF;
            state[I_OFF]:  if (expire_c) state_next = last_c ? ST_IDLE : ST_ON;
            state[I_ECHO]: if (expire_c) state_next = go_play_c ? ST_ON : ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Display decode: only PLAY_ON and ECHO light a color
    always_comb begin
        color_on = 4'b0000;
        if (state[I_ON])        color_on = 4'b0001 << Seq_color;
        else if (state[I_ECHO]) color_on = 4'b0001 << echo_color;
    end

    assign q_Idle     = state[I_IDLE];
    assign q_Play_On  = state[I_ON];
    assign q_Play_Off = state[I_OFF];
    assign q_Echo     = state[I_ECHO];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tcnt       <= '0;
            len_q      <= '0;
            pending    <= 1'b0;
            Seq_addr   <= '0;
            busy       <= 1'b0;
            play_done  <= 1'b0;
            echo_valid <= 1'b0;
            echo_color <= 2'd0;
        end else begin
            play_done  <= 1'b0;
            echo_valid <= 1'b0;
            busy       <= ~state_next[I_IDLE];

            // A Tick on the entry edge belongs to the state being left
            if (state_next != state) tcnt <= '0;
            else if (Tick)           tcnt <= tcnt + TCNT_W'(1);

            case (1'b1)
                state[I_IDLE]: begin
                    if (Start_play) begin
                        len_q <= eff_len_c;
                        if (len_nz_c) Seq_addr  <= '0;
                        else          play_done <= 1'b1;
                    end else if (btn_any_c) begin
                        echo_color <= btn_code_c;
                        echo_valid <= 1'b1;
                    end
                end
                state[I_OFF]: begin
                    if (expire_c) begin
                        if (last_c) play_done <= 1'b1;
                        else        Seq_addr  <= Seq_addr + ADDR_W'(1);
                    end
                end
                state[I_ECHO]: begin
                    if (Start_play && len_nz_c) begin
                        pending <= 1'b1;
                        len_q   <= eff_len_c;
                    end
                    if (expire_c && go_play_c) begin
                        pending  <= 1'b0;
                        Seq_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
